// File: rtl/wb_regbank_ext_if.sv
// rtl/wb_regbank_ext_if.sv - Wishbone pipelined bus bundle for the external-capable register bank
interface wb_regbank_ext_if #(
  parameter int ADR_W  = 2,
  parameter int DATA_W = 32
);
  logic                  wb_cyc_i;
  logic                  wb_stb_i;
  logic                  wb_we_i;
  logic [ADR_W+1:2]      wb_adr_i;
  logic [DATA_W/8-1:0]   wb_sel_i;
  logic [DATA_W-1:0]     wb_dat_i;
  logic                  wb_ack_o;
  logic                  wb_err_o;
  logic                  wb_stall_o;
  logic                  wb_rty_o;
  logic [DATA_W-1:0]     wb_dat_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_ack_o, wb_err_o, wb_stall_o, wb_rty_o, wb_dat_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_ack_o, wb_err_o, wb_stall_o, wb_rty_o, wb_dat_o
  );
endinterface

// File: rtl/wb_regbank_ext.sv
// rtl/wb_regbank_ext.sv - Wishbone register bank with internal, read-only, strobed and external-handshake registers
module wb_regbank_ext #(
  parameter int                   G_NREGS   = 4,
  parameter int                   G_DATA_W  = 32,
  parameter logic [2*G_NREGS-1:0] G_MODES   = 8'b11_10_01_00,
  parameter int                   G_TIMEOUT = 8,
  localparam int                  ADR_W     = (G_NREGS > 1) ? $clog2(G_NREGS) : 1,
  localparam int                  SEL_W     = G_DATA_W / 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  wb_regbank_ext_if.slave               wb,
  output logic [G_NREGS*G_DATA_W-1:0]   reg_o,
  input  logic [G_NREGS*G_DATA_W-1:0]   reg_i,
  output logic [G_NREGS-1:0]            wr_o,
  output logic [G_NREGS-1:0]            rd_o,
  input  logic [G_NREGS-1:0]            ack_i
);

  typedef enum logic [1:0] {S_IDLE, S_INT, S_EXT, S_DONE} state_t;

  state_t                state;
  state_t                state_nx;
  logic [G_DATA_W-1:0]   regs [G_NREGS];
  logic [ADR_W-1:0]      adr_in;
  logic [ADR_W-1:0]      adr_q;
  logic                  we_q;
  logic [1:0]            mode_q;
  logic [1:0]            mode_in;
  logic [7:0]            cnt;
  logic [G_DATA_W-1:0]   rdata_q;
  logic                  ok_q;
  logic [G_NREGS-1:0]    wr_q;
  logic [G_NREGS-1:0]    rd_q;
  logic                  req;
  logic                  ack_sel;
  logic [G_DATA_W-1:0]   rin_sel;
  logic                  ack;
  logic                  err;

  assign req    = wb.wb_cyc_i & wb.wb_stb_i;
  assign adr_in = wb.wb_adr_i;

  // Unmapped addresses decode as mode 0 but match no register, so they read 0 and drop writes.
  always_comb begin
    mode_in = 2'd0;
    ack_sel = 1'b0;
    rin_sel = '0;
    for (int k = 0; k < G_NREGS; k++) begin
      if (32'(adr_in) == k) mode_in = G_MODES[2*k +: 2];
      if (32'(adr_q) == k) begin
        ack_sel = ack_i[k];
        rin_sel = reg_i[k*G_DATA_W +: G_DATA_W];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ack      = 1'b0;
    err      = 1'b0;
    case (state)
      S_IDLE: if (req) state_nx = (mode_in == 2'd3) ? S_EXT : S_INT;
      S_INT: begin
        ack      = 1'b1;
        state_nx = S_IDLE;
      end
      S_EXT: if (ack_sel || cnt == 8'(G_TIMEOUT - 1)) state_nx = S_DONE;
      default: begin
        ack      = ok_q;
        err      = ~ok_q;
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < G_NREGS; k++) regs[k] <= '0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      mode_q  <= 2'd0;
      cnt     <= '0;
      rdata_q <= '0;
      ok_q    <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      wr_q <= '0;
      rd_q <= '0;
      case (state)
        S_IDLE: if (req) begin
          adr_q   <= adr_in;
          we_q    <= wb.wb_we_i;
          mode_q  <= mode_in;
          cnt     <= '0;
          rdata_q <= '0;
          for (int k = 0; k < G_NREGS; k++) begin
            if (32'(adr_in) == k) begin
              case (G_MODES[2*k +: 2])
                2'd0, 2'd2: begin
                  if (wb.wb_we_i) begin
                    for (int b = 0; b < SEL_W; b++)
                      if (wb.wb_sel_i[b]) regs[k][8*b +: 8] <= wb.wb_dat_i[8*b +: 8];
                  end else begin
                    rdata_q <= regs[k];
                  end
                end
                2'd1: if (!wb.wb_we_i) rdata_q <= reg_i[k*G_DATA_W +: G_DATA_W];
                default: begin
                  // External writes carry the full word regardless of byte lanes.
                  if (wb.wb_we_i) begin
                    regs[k] <= wb.wb_dat_i;
                    wr_q[k] <= 1'b1;
                  end else begin
                    rd_q[k] <= 1'b1;
                  end
                end
              endcase
            end
          end
        end
        S_INT: begin
          if (we_q && mode_q == 2'd2)
            for (int k = 0; k < G_NREGS; k++)
              if (32'(adr_q) == k) wr_q[k] <= 1'b1;
        end
        S_EXT: begin
          cnt  <= cnt + 8'd1;
          ok_q <= ack_sel;
          if (ack_sel && !we_q) rdata_q <= rin_sel;
        end
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < G_NREGS; k++) begin : g_reg_o
    assign reg_o[k*G_DATA_W +: G_DATA_W] = regs[k];
  end

  assign wr_o          = wr_q;
  assign rd_o          = rd_q;
  assign wb.wb_ack_o   = ack;
  assign wb.wb_err_o   = err;
  assign wb.wb_rty_o   = 1'b0;
  assign wb.wb_stall_o = req & (state != S_IDLE);
  assign wb.wb_dat_o   = ack ? rdata_q : '0;

endmodule
